seq_divider: RTL

//   Multi-cycle restoring divider: the subtractive counterpart of the pipeline's combinational adder.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle for the multi-cycle divider: master issues operands, slave returns
// quotient (LO), remainder (HI) and the divide-by-zero flag.
interface seq_divider_if #(
  parameter int WL = 32
);
  logic          start;
  logic          is_signed;
  logic [WL-1:0] dividend;
  logic [WL-1:0] divisor;
  logic          busy;
  logic          done;
  logic [WL-1:0] quotient;
  logic [WL-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, signed (DIV) or unsigned (DIVU) per request.
// Optional build macro SEQ_DIVIDER_EARLY_TERM_EN: skip the iteration when |dividend| < |divisor|.
module seq_divider #(
  parameter int WL = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = (WL > 1) ? $clog2(WL) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WL-1:0] r_rem;
  logic [WL-1:0] r_quo;
  logic [WL-1:0] r_dvsr;
  logic          r_neg_dvd;
  logic          r_neg_dvs;
  logic          r_zero;
  logic          r_early;
  logic          r_busy;
  logic          r_done;
  logic [WL-1:0] r_quotient;
  logic [WL-1:0] r_remainder;
  logic          r_dbz;

  logic          w_dvd_neg;
  logic          w_dvs_neg;
  logic [WL-1:0] w_dvd_abs;
  logic [WL-1:0] w_dvs_abs;
  logic          w_early;
  logic [WL:0]   w_shift;
  logic [WL:0]   w_diff;
  logic          w_ge;
  logic [WL-1:0] w_dvd_orig;
  logic [WL-1:0] w_quo_fix;
  logic [WL-1:0] w_rem_fix;

  assign w_dvd_neg = bus.is_signed & bus.dividend[WL-1];
  assign w_dvs_neg = bus.is_signed & bus.divisor[WL-1];
  assign w_dvd_abs = w_dvd_neg ? (WL'(0) - bus.dividend) : bus.dividend;
  assign w_dvs_abs = w_dvs_neg ? (WL'(0) - bus.divisor) : bus.divisor;

`ifdef SEQ_DIVIDER_EARLY_TERM_EN
  assign w_early = (w_dvd_abs < w_dvs_abs);
`else
  assign w_early = 1'b0;
`endif

  // WL+1-bit trial subtraction: the shifted partial remainder can exceed WL bits.
  assign w_shift = {r_rem, r_quo[WL-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});

  // r_quo still holds |dividend| on the bypass paths; re-signing it restores the raw operand.
  assign w_dvd_orig = r_neg_dvd ? (WL'(0) - r_quo) : r_quo;
  assign w_quo_fix  = (r_neg_dvd ^ r_neg_dvs) ? (WL'(0) - r_quo) : r_quo;
  assign w_rem_fix  = r_neg_dvd ? (WL'(0) - r_rem) : r_rem;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_neg_dvd   <= 1'b0;
      r_neg_dvs   <= 1'b0;
      r_zero      <= 1'b0;
      r_early     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_quo     <= w_dvd_abs;
            r_dvsr    <= w_dvs_abs;
            r_neg_dvd <= w_dvd_neg;
            r_neg_dvs <= w_dvs_neg;
            r_rem     <= '0;
            r_cnt     <= CW'(WL - 1);
            r_busy    <= 1'b1;
            r_zero    <= (bus.divisor == '0);
            r_early   <= (bus.divisor != '0) && w_early;
            // Bypass cases still pass through FIX so done lands one edge after start.
            if ((bus.divisor == '0) || w_early) r_state <= S_FIX;
            else                                r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff[WL-1:0] : w_shift[WL-1:0];
          r_quo <= {r_quo[WL-2:0], w_ge};
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= w_dvd_orig;
            r_dbz       <= 1'b1;
          end else if (r_early) begin
            r_quotient  <= '0;
            r_remainder <= w_dvd_orig;
            r_dbz       <= 1'b0;
          end else begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
            r_dbz       <= 1'b0;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule
